eth_reset_sequencer: RTL



---
 rtl/eth_reset_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 20 ++
 rtl/eth_reset_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/eth_reset_pkg.sv
// Shared types and helpers for the Ethernet reset sequencer.
package eth_reset_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_MMCM = 3'd1,
    PMA_RST   = 3'd2,
    WAIT_PLL  = 3'd3,
    AXI_REL   = 3'd4,
    RUN       = 3'd5
  } eth_rst_state_t;

  // Width of the shared state counter: wide enough for the largest duration plus one bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous status inputs.
// The flops are deliberately not reset so they keep tracking the input through reset.
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    meta_reg <= d;
    sync_reg <= meta_reg;
  end

  assign q = sync_reg;

endmodule

// File: rtl/eth_reset_sequencer.sv
// Reset sequencer for the 1000BASE-X/SGMII Ethernet wrapper: releases PMA, AXI-Lite and
// MAC resets in order once MMCM and GT PLL0 are stably locked, retries the PMA reset on
// PLL lock timeout, and re-sequences when lock is lost.
module eth_reset_sequencer
  import eth_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 2000,
  parameter int PMA_RST_CYCLES      = 200,
  parameter int AXI_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 200000
) (
  input  logic       ref_clk,
  input  logic       glbl_rst,
  input  logic       mmcm_locked,
  input  logic       gt0_pll0lock_in,
  input  logic       gt0_pll0refclklost_in,
  output logic       pma_reset,
  output logic       mac_glbl_rst,
  output logic       s_axi_lite_resetn,
  output logic       reset_done,
  output logic [7:0] retry_cnt
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, PMA_RST_CYCLES,
                                AXI_RST_CYCLES, LOCK_TIMEOUT_CYCLES);

  // Terminal counts: a state exits on the edge where its counter holds N-1.
  localparam logic [CW-1:0] LS_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] PMA_LAST = CW'(PMA_RST_CYCLES - 1);
  localparam logic [CW-1:0] AXI_LAST = CW'(AXI_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

  logic [2:0] async_vec;
  logic [2:0] sync_vec;
  logic       mmcm_s;
  logic       pll_s;
  logic       lost_s;
  logic       pll_ok;

  eth_rst_state_t state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [CW-1:0]  tmo_reg, tmo_next;
  logic [7:0]     retry_reg, retry_next;

  logic pma_reset_reg, pma_reset_next;
  logic mac_rst_reg, mac_rst_next;
  logic axi_resetn_reg, axi_resetn_next;
  logic done_reg, done_next;

  assign async_vec = {gt0_pll0refclklost_in, gt0_pll0lock_in, mmcm_locked};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      sync_2ff u_sync (
        .clk (ref_clk),
        .d   (async_vec[gi]),
        .q   (sync_vec[gi])
      );
    end
  endgenerate

  assign mmcm_s = sync_vec[0];
  assign pll_s  = sync_vec[1];
  assign lost_s = sync_vec[2];
  assign pll_ok = pll_s & ~lost_s;

  // State, counters and retry count registers.
  always_ff @(posedge ref_clk) begin
    if (glbl_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tmo_reg   <= '0;
      retry_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tmo_reg   <= tmo_next;
      retry_reg <= retry_next;
    end
  end

  // Next-state, counter and retry logic; lock-loss faults override normal progress.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    tmo_next   = '0;
    retry_next = retry_reg;

    unique case (state_reg)
      IDLE: state_next = WAIT_MMCM;
      WAIT_MMCM: begin
        if (!mmcm_s)                 cnt_next   = '0;
        else if (cnt_reg == LS_LAST) state_next = PMA_RST;
      end
      PMA_RST: begin
        if (cnt_reg == PMA_LAST) state_next = WAIT_PLL;
      end
      WAIT_PLL: begin
        tmo_next = tmo_reg + CW'(1);
        if (!pll_ok) cnt_next = '0;
        // Reaching stability on the timeout cycle still counts as success.
        if (pll_ok && (cnt_reg == LS_LAST)) state_next = AXI_REL;
        else if (tmo_reg == TMO_LAST)       state_next = PMA_RST;
      end
      AXI_REL: begin
        if (cnt_reg == AXI_LAST) state_next = RUN;
      end
      RUN:     cnt_next = '0;
      default: state_next = IDLE;
    endcase

    // Loss of MMCM lock restarts everything; PLL loss after release only redoes the PMA reset.
    if (state_reg inside {PMA_RST, WAIT_PLL, AXI_REL, RUN}) begin
      if (!mmcm_s) begin
        state_next = IDLE;
      end else if (!pll_ok && (state_reg inside {AXI_REL, RUN})) begin
        state_next = PMA_RST;
      end
    end

    // WAIT_PLL only falls back to PMA_RST through the lock timeout.
    if ((state_reg == WAIT_PLL) && (state_next == PMA_RST) && (retry_reg != 8'hFF)) begin
      retry_next = retry_reg + 8'd1;
    end

    if (state_next != state_reg) begin
      cnt_next = '0;
      tmo_next = '0;
    end
  end

  // Output decode from the next state so outputs move on the same edge as the state.
  always_comb begin
    pma_reset_next  = 1'b1;
    mac_rst_next    = 1'b1;
    axi_resetn_next = 1'b0;
    done_next       = 1'b0;
    case (state_next)
      WAIT_PLL: pma_reset_next = 1'b0;
      AXI_REL: begin
        pma_reset_next  = 1'b0;
        axi_resetn_next = 1'b1;
      end
      RUN: begin
        pma_reset_next  = 1'b0;
        mac_rst_next    = 1'b0;
        axi_resetn_next = 1'b1;
        done_next       = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered reset outputs.
  always_ff @(posedge ref_clk) begin
    if (glbl_rst) begin
      pma_reset_reg  <= 1'b1;
      mac_rst_reg    <= 1'b1;
      axi_resetn_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      pma_reset_reg  <= pma_reset_next;
      mac_rst_reg    <= mac_rst_next;
      axi_resetn_reg <= axi_resetn_next;
      done_reg       <= done_next;
    end
  end

  assign pma_reset         = pma_reset_reg;
  assign mac_glbl_rst      = mac_rst_reg;
  assign s_axi_lite_resetn = axi_resetn_reg;
  assign reset_done        = done_reg;
  assign retry_cnt         = retry_reg;

endmodule
